// File: rtl/scan_sequencer.sv
// Tactile-array scan sequencer: steps switch/read selects over every point, settles,
// triggers one ADC conversion per point and strobes the sample into the frame store.
// Optional ADC timeout recovery is enabled by defining SCAN_TIMEOUT_EN.
module scan_sequencer #(
    parameter int SW_WIRE_CNT    = 16,
    parameter int RD_WIRE_CNT    = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk_write,
    input  logic                           rst_n,
    input  logic                           start_in,
    input  logic                           continuous_in,
    input  logic                           stop_in,
    input  logic [11:0]                    adc_data_in,
    input  logic                           adc_valid_in,
    output logic                           adc_trigger_out,
    output logic [$clog2(SW_WIRE_CNT):0]   sw_select_out,
    output logic [$clog2(RD_WIRE_CNT):0]   rd_select_out,
    output logic [$clog2(SW_WIRE_CNT):0]   sw_write_out,
    output logic [$clog2(RD_WIRE_CNT):0]   rd_write_out,
    output logic [11:0]                    data_out,
    output logic                           data_valid_out,
    output logic                           busy_out,
    output logic                           frame_done_out,
    output logic [15:0]                    frame_count_out,
    output logic                           error_out
);
    localparam int SW_W    = $clog2(SW_WIRE_CNT) + 1;
    localparam int RD_W    = $clog2(RD_WIRE_CNT) + 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [SW_W-1:0] SW_LAST = SW_W'(SW_WIRE_CNT - 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(RD_WIRE_CNT - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, WRITE} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              last_point, valid_ok, timeout_hit;

    logic [SW_W-1:0]   sw_sel_d, sw_wr_d;
    logic [RD_W-1:0]   rd_sel_d, rd_wr_d;
    logic [11:0]       data_d;
    logic [15:0]       fc_d;
    logic              trig_d, dv_d, fd_d, busy_d;

    assign last_point = (sw_select_out == SW_LAST) && (rd_select_out == RD_LAST);
    // The registered trigger is high exactly in the trigger cycle, where valid is ignored.
    assign valid_ok   = adc_valid_in && !adc_trigger_out;

`ifdef SCAN_TIMEOUT_EN
    assign timeout_hit = (state == CONVERT) && !valid_ok && (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            sw_select_out   <= '0;
            rd_select_out   <= '0;
            sw_write_out    <= '0;
            rd_write_out    <= '0;
            data_out        <= '0;
            frame_count_out <= '0;
            adc_trigger_out <= 1'b0;
            data_valid_out  <= 1'b0;
            frame_done_out  <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            state           <= next_state;
            cnt             <= (state == IDLE || next_state != state) ? '0 : cnt + 1'b1;
            sw_select_out   <= sw_sel_d;
            rd_select_out   <= rd_sel_d;
            sw_write_out    <= sw_wr_d;
            rd_write_out    <= rd_wr_d;
            data_out        <= data_d;
            frame_count_out <= fc_d;
            adc_trigger_out <= trig_d;
            data_valid_out  <= dv_d;
            frame_done_out  <= fd_d;
            busy_out        <= busy_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_in) next_state = SETTLE;
            SETTLE:  if (cnt == CNT_W'(SETTLE_CYCLES - 1)) next_state = CONVERT;
            CONVERT: if (valid_ok || timeout_hit) next_state = WRITE;
            WRITE:   next_state = (!last_point || continuous_in) ? SETTLE : IDLE;
            default: next_state = IDLE;
        endcase
        if (stop_in) next_state = IDLE;
    end

    // Computes next values of the registered outputs from the transition being taken.
    always_comb begin
        sw_sel_d = sw_select_out;
        rd_sel_d = rd_select_out;
        sw_wr_d  = sw_write_out;
        rd_wr_d  = rd_write_out;
        data_d   = data_out;
        fc_d     = frame_count_out;
        trig_d   = (next_state == CONVERT) && (state != CONVERT);
        dv_d     = (next_state == WRITE);
        fd_d     = (next_state == WRITE) && last_point;
        busy_d   = (next_state != IDLE);

        if (next_state == WRITE) begin
            sw_wr_d = sw_select_out;
            rd_wr_d = rd_select_out;
            data_d  = valid_ok ? adc_data_in : 12'hFFF;
        end

        if (state == WRITE && !stop_in) begin
            if (rd_select_out == RD_LAST) begin
                rd_sel_d = '0;
                sw_sel_d = (sw_select_out == SW_LAST) ? '0 : sw_select_out + 1'b1;
            end else begin
                rd_sel_d = rd_select_out + 1'b1;
            end
            if (last_point) fc_d = frame_count_out + 16'd1;
        end

        if (next_state == IDLE) begin
            sw_sel_d = '0;
            rd_sel_d = '0;
        end
    end

`ifdef SCAN_TIMEOUT_EN
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            error_out <= 1'b0;
        end else if (timeout_hit && next_state == WRITE) begin
            error_out <= 1'b1;
        end else if (state == IDLE && start_in && !stop_in) begin
            error_out <= 1'b0;
        end
    end
`else
    assign error_out = 1'b0;
`endif

endmodule
